// File: rtl/servant_rst_seq.sv
// Reset sequencer: synchronises PLL lock, qualifies it, then releases N_RST reset domains in ascending order.
// Optional PLL lock-wait timeout with PLL reset pulse: define SERVANT_RST_SEQ_PLL_TIMEOUT_EN.
module servant_rst_seq #(
   parameter int unsigned N_RST          = 3,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned LOCK_CYCLES    = 16,
   parameter int unsigned STAGE_DELAY    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65536,
   parameter int unsigned PLL_RST_CYCLES = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_locked,
   input  logic             i_sw_rst,
   output logic [N_RST-1:0] o_rst,
   output logic             o_ready,
   output logic             o_pll_rst
);

   localparam int unsigned MAX_A   = (LOCK_CYCLES > STAGE_DELAY) ? LOCK_CYCLES : STAGE_DELAY;
   localparam int unsigned MAX_B   = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int unsigned MAX_C   = (MAX_B > PLL_RST_CYCLES) ? MAX_B : PLL_RST_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_C) + 1;
   localparam int unsigned STAGE_W = $clog2(N_RST) + 1;

   typedef enum logic [2:0] {
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
`ifdef SERVANT_RST_SEQ_PLL_TIMEOUT_EN
      , PLL_RST
`endif
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [STAGE_W-1:0]     stage_q, stage_d;
   logic [N_RST-1:0]       rst_d;
   logic                   ready_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;
   logic                   abort;

   // Only this chain samples the asynchronous lock input.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], i_locked};
   end

   assign locked_s = sync_q[SYNC_STAGES-1];
   assign abort    = !locked_s || i_sw_rst;

`ifdef SERVANT_RST_SEQ_PLL_TIMEOUT_EN
   logic pll_rst_q, pll_rst_d;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) pll_rst_q <= 1'b0;
      else          pll_rst_q <= pll_rst_d;
   end

   assign o_pll_rst = pll_rst_q;
`else
   assign o_pll_rst = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         stage_q <= '0;
         o_rst   <= '1;
         o_ready <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         o_rst   <= rst_d;
         o_ready <= ready_d;
      end
   end

   // Next state, counters and registered reset outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      rst_d   = o_rst;
      ready_d = o_ready;
`ifdef SERVANT_RST_SEQ_PLL_TIMEOUT_EN
      pll_rst_d = 1'b0;
`endif

      case (state_q)
         WAIT_LOCK: begin
            rst_d   = '1;
            ready_d = 1'b0;
            stage_d = '0;
            if (locked_s && !i_sw_rst) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else begin
`ifdef SERVANT_RST_SEQ_PLL_TIMEOUT_EN
               if (!locked_s) begin
                  if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                     state_d   = PLL_RST;
                     cnt_d     = '0;
                     pll_rst_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
`else
               cnt_d = '0;
`endif
            end
         end

         STABLE: begin
            if (abort) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               stage_d = '0;
               rst_d   = '1;
               ready_d = 1'b0;
            end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
               state_d = RELEASE;
               cnt_d   = '0;
               stage_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         RELEASE: begin
            if (abort) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               stage_d = '0;
               rst_d   = '1;
               ready_d = 1'b0;
            end else if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
               for (int unsigned i = 0; i < N_RST; i++) begin
                  if (stage_q == STAGE_W'(i)) rst_d[i] = 1'b0;
               end
               cnt_d   = '0;
               stage_d = stage_q + STAGE_W'(1);
               if (stage_q == STAGE_W'(N_RST - 1)) begin
                  state_d = RUN;
                  stage_d = '0;
                  ready_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         RUN: begin
            rst_d   = '0;
            ready_d = 1'b1;
            if (abort) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               stage_d = '0;
               rst_d   = '1;
               ready_d = 1'b0;
            end
         end

`ifdef SERVANT_RST_SEQ_PLL_TIMEOUT_EN
         // Fixed-length PLL reset pulse; lock and software reset are ignored here.
         PLL_RST: begin
            rst_d   = '1;
            ready_d = 1'b0;
            if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
               state_d   = WAIT_LOCK;
               cnt_d     = '0;
               pll_rst_d = 1'b0;
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
               pll_rst_d = 1'b1;
            end
         end
`endif

         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            stage_d = '0;
            rst_d   = '1;
            ready_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_servant_rst_seq.sv
// Scoreboard bench for servant_rst_seq: expected {o_pll_rst, o_ready, o_rst} queued per edge and checked at negedge.
module tb_servant_rst_seq;

`ifdef SERVANT_RST_SEQ_PLL_TIMEOUT_EN
   localparam int unsigned TO = 32;
`else
   localparam int unsigned TO = 65536;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_locked = 1'b0;
   logic       i_sw_rst = 1'b0;
   logic [2:0] o_rst;
   logic       o_ready;
   logic       o_pll_rst;

   servant_rst_seq #(
      .N_RST(3), .SYNC_STAGES(2), .LOCK_CYCLES(16), .STAGE_DELAY(4),
      .TIMEOUT_CYCLES(TO), .PLL_RST_CYCLES(8)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_locked(i_locked), .i_sw_rst(i_sw_rst),
      .o_rst(o_rst), .o_ready(o_ready), .o_pll_rst(o_pll_rst)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int         cyc;
      logic [4:0] val;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   base = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got 0x%0h, want 0x%0h", tag, cyc, act, exp);
      end
   endtask

   task automatic exp_at(input int e, input logic [2:0] r, input logic rdy, input logic pll,
                         input string tag);
      exp_t x;
      x.cyc = base + e;
      x.val = {pll, rdy, r};
      x.tag = tag;
      q.push_back(x);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Pops every expectation due at this edge count.
   always @(negedge i_clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         if (q[0].cyc < cyc) chk({q[0].tag, "_sched"}, 32'(cyc), 32'(q[0].cyc));
         else                chk(q[0].tag, {27'd0, o_pll_rst, o_ready, o_rst}, {27'd0, q[0].val});
         void'(q.pop_front());
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held low for three edges.
      base = 0;
      exp_at(1, 3'b111, 1'b0, 1'b0, "rst_e1");
      exp_at(3, 3'b111, 1'b0, 1'b0, "rst_e3");
      step(3);

      // Nominal release sequence.
      i_rst_n = 1'b1; i_locked = 1'b1; base = cyc;
      exp_at(22, 3'b111, 1'b0, 1'b0, "rel_pre");
      exp_at(23, 3'b110, 1'b0, 1'b0, "rel_d0");
      exp_at(26, 3'b110, 1'b0, 1'b0, "rel_d0_hold");
      exp_at(27, 3'b100, 1'b0, 1'b0, "rel_d1");
      exp_at(30, 3'b100, 1'b0, 1'b0, "rel_d1_hold");
      exp_at(31, 3'b000, 1'b1, 1'b0, "rel_d2_ready");
      exp_at(35, 3'b000, 1'b1, 1'b0, "run_hold");
      step(35);

      // Lock loss in RUN.
      i_locked = 1'b0; base = cyc;
      exp_at(2, 3'b000, 1'b1, 1'b0, "loss_pre");
      exp_at(3, 3'b111, 1'b0, 1'b0, "loss_assert");
      step(6);

      // Single-cycle lock glitch restarts qualification.
      i_locked = 1'b1; base = cyc;
      exp_at(20, 3'b111, 1'b0, 1'b0, "glitch_mid");
      exp_at(33, 3'b111, 1'b0, 1'b0, "glitch_pre");
      exp_at(34, 3'b110, 1'b0, 1'b0, "glitch_d0");
      exp_at(38, 3'b100, 1'b0, 1'b0, "glitch_d1");
      exp_at(41, 3'b100, 1'b0, 1'b0, "glitch_d2_pre");
      exp_at(42, 3'b000, 1'b1, 1'b0, "glitch_ready");
      step(10);
      i_locked = 1'b0;
      step(1);
      i_locked = 1'b1;
      step(34);

      // Software reset pulse mid-release, then chip reset mid-release.
      i_locked = 1'b0;
      step(6);
      i_locked = 1'b1; base = cyc;
      exp_at(23, 3'b110, 1'b0, 1'b0, "abort_d0");
      exp_at(25, 3'b110, 1'b0, 1'b0, "abort_pre");
      exp_at(26, 3'b111, 1'b0, 1'b0, "abort_assert");
      exp_at(46, 3'b111, 1'b0, 1'b0, "abort_re_pre");
      exp_at(47, 3'b110, 1'b0, 1'b0, "abort_re_d0");
      exp_at(50, 3'b111, 1'b0, 1'b0, "rstmid_assert");
      step(25);
      i_sw_rst = 1'b1;
      step(1);
      i_sw_rst = 1'b0;
      step(23);
      i_rst_n = 1'b0;
      step(2);
      i_rst_n = 1'b1; base = cyc;
      exp_at(22, 3'b111, 1'b0, 1'b0, "rstmid_pre");
      exp_at(23, 3'b110, 1'b0, 1'b0, "rstmid_d0");
      exp_at(31, 3'b000, 1'b1, 1'b0, "rstmid_ready");
      step(33);

      // Software reset held high pins the block in WAIT_LOCK.
      i_sw_rst = 1'b1; base = cyc;
      exp_at(1, 3'b111, 1'b0, 1'b0, "swhold_assert");
      exp_at(40, 3'b111, 1'b0, 1'b0, "swhold_hold");
      step(40);
      i_sw_rst = 1'b0; base = cyc;
      exp_at(20, 3'b111, 1'b0, 1'b0, "swrel_pre");
      exp_at(21, 3'b110, 1'b0, 1'b0, "swrel_d0");
      exp_at(29, 3'b000, 1'b1, 1'b0, "swrel_ready");
      step(31);

`ifdef SERVANT_RST_SEQ_PLL_TIMEOUT_EN
      // Lock never arrives: periodic PLL reset pulses.
      i_rst_n = 1'b0; i_locked = 1'b0;
      step(2);
      i_rst_n = 1'b1; base = cyc;
      exp_at(31, 3'b111, 1'b0, 1'b0, "to_pre");
      exp_at(32, 3'b111, 1'b0, 1'b1, "to_pulse_start");
      exp_at(39, 3'b111, 1'b0, 1'b1, "to_pulse_last");
      exp_at(40, 3'b111, 1'b0, 1'b0, "to_pulse_end");
      exp_at(71, 3'b111, 1'b0, 1'b0, "to_pre2");
      exp_at(72, 3'b111, 1'b0, 1'b1, "to_pulse2");
      step(75);
`endif

      step(2);
      chk("drain", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
